// File: rtl/if_stage.sv
// if_stage: RV32I fetch stage owning the PC, IF/ID register, redirect/stall/flush and self-loop halt.
// Optional define IF_MISALIGN_TRAP_EN sends misaligned redirects to TRAP_VEC and reports them.
module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
  parameter bit          HALT_DETECT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_plus4_o,
  output logic        id_valid_o,
  output logic [31:0] fetch_count_o,
`ifdef IF_MISALIGN_TRAP_EN
  output logic        misalign_o,
  output logic [31:0] misalign_addr_o,
`endif
  output logic        halted_o
);
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] SELF_JUMP = 32'h0000_006f;
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t r_state, w_state;
  logic [31:0] r_pc, w_pc, r_instr, w_instr, r_id_pc, w_id_pc, r_id_pc4, w_id_pc4;
  logic [31:0] r_count, w_count, w_pc4, w_target;
  logic        r_valid, w_valid, w_mis;
  assign w_pc4 = r_pc + 32'd4;
`ifdef IF_MISALIGN_TRAP_EN
  logic        r_mis;
  logic [31:0] r_mis_addr;
  assign w_mis = (r_state == RUN) && redirect_i && (redirect_pc_i[1:0] != 2'b00);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mis      <= 1'b0;
      r_mis_addr <= 32'h0;
    end else begin
      r_mis <= w_mis;
      if (w_mis) r_mis_addr <= redirect_pc_i;
    end
  end
  assign misalign_o      = r_mis;
  assign misalign_addr_o = r_mis_addr;
`else
  assign w_mis = 1'b0;
`endif
  // Without the trap, the low target bits are simply dropped.
  assign w_target = w_mis ? TRAP_VEC : (redirect_pc_i & ~32'h3);
  always_comb begin
    w_state  = r_state;
    w_pc     = r_pc;
    w_instr  = r_instr;
    w_id_pc  = r_id_pc;
    w_id_pc4 = r_id_pc4;
    w_valid  = r_valid;
    w_count  = r_count;
    if (r_state == BOOT) begin
      w_state = RUN;
      w_instr = NOP;
      w_valid = 1'b0;
    end else if (r_state == RUN) begin
      if (redirect_i) begin
        w_pc    = w_target;
        w_instr = NOP;
        w_valid = 1'b0;
      end else if (stall_i) begin
        w_instr = flush_i ? NOP : r_instr;
        w_valid = flush_i ? 1'b0 : r_valid;
      end else begin
        w_pc = w_pc4;
        if (flush_i) begin
          w_instr = NOP;
          w_valid = 1'b0;
        end else begin
          w_instr  = imem_instr_i;
          w_id_pc  = r_pc;
          w_id_pc4 = w_pc4;
          w_valid  = 1'b1;
          w_count  = r_count + 32'd1;
          if (HALT_DETECT && imem_instr_i == SELF_JUMP) w_state = HALT;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= BOOT;
      r_pc     <= RESET_PC;
      r_instr  <= NOP;
      r_id_pc  <= 32'h0;
      r_id_pc4 <= 32'h0;
      r_valid  <= 1'b0;
      r_count  <= 32'h0;
    end else begin
      r_state  <= w_state;
      r_pc     <= w_pc;
      r_instr  <= w_instr;
      r_id_pc  <= w_id_pc;
      r_id_pc4 <= w_id_pc4;
      r_valid  <= w_valid;
      r_count  <= w_count;
    end
  end
  assign imem_addr_o   = r_pc;
  assign id_instr_o    = r_instr;
  assign id_pc_o       = r_id_pc;
  assign id_pc_plus4_o = r_id_pc4;
  assign id_valid_o    = r_valid;
  assign fetch_count_o = r_count;
  assign halted_o      = (r_state == HALT);
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: random stall/flush/redirect traffic against a fetch model, plus directed corner cases.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        stall_i = 1'b0, flush_i = 1'b0, redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0, imem_instr_i = 32'h0;
  logic [31:0] imem_addr_o, id_instr_o, id_pc_o, id_pc_plus4_o, fetch_count_o;
  logic        id_valid_o, halted_o;
`ifdef IF_MISALIGN_TRAP_EN
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
`endif
  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_addr_o(imem_addr_o), .imem_instr_i(imem_instr_i),
    .id_instr_o(id_instr_o), .id_pc_o(id_pc_o), .id_pc_plus4_o(id_pc_plus4_o),
    .id_valid_o(id_valid_o), .fetch_count_o(fetch_count_o),
`ifdef IF_MISALIGN_TRAP_EN
    .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o),
`endif
    .halted_o(halted_o)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic [31:0] mem [0:255];
  logic [31:0] m_pc, m_instr, m_id_pc, m_id_pc4, m_count, m_mis_addr;
  logic        m_valid, m_halted, m_boot, m_mis;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Low 1 KiB is a table; above it a fixed scramble that never yields the self-jump (bit 4 forced).
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a < 32'd1024) ? mem[a[9:2]] : (({a[15:0], a[31:16]} ^ 32'h5a5a_0000) | 32'h10);
  endfunction
  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_id_pc = 32'h0; m_id_pc4 = 32'h0; m_count = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_boot = 1'b1; m_mis = 1'b0; m_mis_addr = 32'h0;
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".pc"}, imem_addr_o, m_pc);
    chk({tag, ".instr"}, id_instr_o, m_instr);
    chk({tag, ".valid"}, {31'h0, id_valid_o}, {31'h0, m_valid});
    chk({tag, ".count"}, fetch_count_o, m_count);
    chk({tag, ".halted"}, {31'h0, halted_o}, {31'h0, m_halted});
    if (m_valid) begin
      chk({tag, ".id_pc"}, id_pc_o, m_id_pc);
      chk({tag, ".id_pc4"}, id_pc_plus4_o, m_id_pc4);
    end
`ifdef IF_MISALIGN_TRAP_EN
    chk({tag, ".mis"}, {31'h0, misalign_o}, {31'h0, m_mis});
    chk({tag, ".mis_addr"}, misalign_addr_o, m_mis_addr);
`endif
  endtask
  task automatic step(input string tag, input logic s, input logic f, input logic r, input logic [31:0] t);
    logic [31:0] w;
    stall_i = s; flush_i = f; redirect_i = r; redirect_pc_i = t;
    imem_instr_i = word(imem_addr_o);
    @(posedge clk);
    m_mis = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0; m_valid = 1'b0; m_instr = NOP;
    end else if (!m_halted) begin
      if (r) begin
`ifdef IF_MISALIGN_TRAP_EN
        m_mis = (t % 4) != 0;
        if (m_mis) m_mis_addr = t;
        m_pc = m_mis ? 32'h100 : t;
`else
        m_pc = t - (t % 4);
`endif
        m_valid = 1'b0; m_instr = NOP;
      end else if (s) begin
        if (f) begin m_valid = 1'b0; m_instr = NOP; end
      end else begin
        w = word(m_pc);
        if (f) begin
          m_valid = 1'b0; m_instr = NOP;
        end else begin
          m_instr = w; m_id_pc = m_pc; m_id_pc4 = m_pc + 4; m_valid = 1'b1; m_count++;
          if (w == 32'h6f) m_halted = 1'b1;
        end
        m_pc = m_pc + 4;
      end
    end
    #1;
    check_all(tag);
  endtask
  task automatic rand_step(input string tag);
    logic [31:0] t;
    t = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom);
    step(tag, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, t);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'h10;
    mem[0] = 32'h0400_0413;
    mem[1] = 32'h0320_0493;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    step("boot", 0, 0, 0, 0);
    step("fetch0", 0, 0, 0, 0);
    step("fetch4", 0, 0, 0, 0);
    chk("count2", fetch_count_o, 32'd2);
    for (int i = 0; i < 3; i++) step("stall", 1, 0, 0, 0);
    chk("stall_pc", imem_addr_o, 32'h8);
    step("resume", 0, 0, 0, 0);
    chk("resume_pc", id_pc_o, 32'h8);
    step("redir_stall_flush", 1, 1, 1, 32'h18);
    chk("redir_pc", imem_addr_o, 32'h18);
    for (int i = 0; i < 400; i++) rand_step("rand");
    step("wrap_redir", 0, 0, 1, 32'hFFFF_FFFC);
    step("wrap", 0, 0, 0, 0);
    chk("wrap_pc4", id_pc_plus4_o, 32'h0);
    mem[12] = 32'h0000_0013;
    mem[13] = 32'h0000_006f;
    step("halt_redir", 0, 0, 1, 32'h30);
    step("halt_pre", 0, 0, 0, 0);
    step("halt_cap", 0, 0, 0, 0);
    chk("halt_id_pc", id_pc_o, 32'h34);
    for (int i = 0; i < 20; i++) rand_step("halted");
    chk("halt_pc_frozen", imem_addr_o, 32'h38);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    #3 rst_n = 1'b1;
    step("boot2", 0, 0, 0, 0);
    step("mis_redir", 0, 0, 1, 32'h22);
    step("mis_after", 0, 0, 0, 0);
    for (int i = 0; i < 200; i++) rand_step("rand2");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
